// File: rtl/module_uart_wr_ctrl_if.sv
// Bus-write, TX handshake and RX capture signals of the UART write-side register block.
// The master modport is the CPU/UART side that drives the block; slave is the block itself.
interface module_uart_wr_ctrl_if;
    logic        we_i;
    logic        addr_i;
    logic [31:0] wdata_i;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_done_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic [31:0] ctrl_reg_o;
    logic [7:0]  rx_data_o;

    modport master (
        output we_i, addr_i, wdata_i, tx_done_i, rx_valid_i, rx_data_i,
        input  tx_start_o, tx_data_o, ctrl_reg_o, rx_data_o
    );

    modport slave (
        input  we_i, addr_i, wdata_i, tx_done_i, rx_valid_i, rx_data_i,
        output tx_start_o, tx_data_o, ctrl_reg_o, rx_data_o
    );
endinterface

// File: rtl/module_uart_wr_ctrl.sv
// UART write-side register block: control/data register decode, TX send FSM and RX byte capture.
// Optional macro UART_RX_OVERRUN_EN adds the sticky overrun flag OVR in control bit2.
module module_uart_wr_ctrl (
    input  logic                 clk_i,
    input  logic                 rst_i,
    module_uart_wr_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_t;

    tx_state_t   state;
    logic        send;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        rx_new;
    logic [7:0]  rx_data;
    logic        ovr;

    logic        ctrl_wr;
    logic        data_wr;
    logic        clr_rx_new;
    logic        unused_wdata;

    assign ctrl_wr    = bus.we_i && !bus.addr_i;
    assign data_wr    = bus.we_i &&  bus.addr_i;
    assign clr_rx_new = ctrl_wr && !bus.wdata_i[1];

    assign unused_wdata = &{1'b0, bus.wdata_i[31:8], bus.wdata_i[2]};

    // TX FSM. While SEND is already pending in IDLE the start is committed,
    // so a control write in that cycle cannot withdraw it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            send     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (send) begin
                        state    <= ST_START;
                        tx_start <= 1'b1;
                    end else if (ctrl_wr) begin
                        send <= bus.wdata_i[0];
                    end
                    if (data_wr) begin
                        tx_data <= bus.wdata_i[7:0];
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.tx_done_i) begin
                        send  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RX capture: a new byte always overwrites, and its set of RX_NEW beats a software clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_new  <= 1'b0;
            rx_data <= 8'h00;
        end else if (bus.rx_valid_i) begin
            rx_new  <= 1'b1;
            rx_data <= bus.rx_data_i;
        end else if (clr_rx_new) begin
            rx_new  <= 1'b0;
        end
    end

`ifdef UART_RX_OVERRUN_EN
    // An unread byte being replaced is an overrun unless software is acknowledging it right now.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovr <= 1'b0;
        end else if (bus.rx_valid_i && rx_new && !clr_rx_new) begin
            ovr <= 1'b1;
        end else if (ctrl_wr && !bus.wdata_i[2]) begin
            ovr <= 1'b0;
        end
    end
`else
    assign ovr = 1'b0;
`endif

    assign bus.tx_start_o = tx_start;
    assign bus.tx_data_o  = tx_data;
    assign bus.ctrl_reg_o = {29'd0, ovr, rx_new, send};
    assign bus.rx_data_o  = rx_data;

endmodule

// File: tb/tb_module_uart_wr_ctrl.sv
// Directed bench for module_uart_wr_ctrl: a transaction-level model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_module_uart_wr_ctrl;

`ifdef UART_RX_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    module_uart_wr_ctrl_if bus ();

    module_uart_wr_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    // Model: SEND plus the number of cycles it has been pending (age, saturating).
    // age 0 = just written, age 1 = start pulse cycle, age >= 2 = waiting for done.
    bit       m_send;
    int       m_age;
    bit       m_new;
    bit       m_ovr;
    bit [7:0] m_txd;
    bit [7:0] m_rxd;
    bit       n_send;
    bit       wr_ctrl;
    bit       clr_new;

    initial begin
        m_send = 0; m_age = 0; m_new = 0; m_ovr = 0; m_txd = 0; m_rxd = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_send = 0; m_age = 0; m_new = 0; m_ovr = 0; m_txd = 0; m_rxd = 0;
        end else begin
            wr_ctrl = bus.we_i && !bus.addr_i;
            clr_new = wr_ctrl && !bus.wdata_i[1];
            n_send  = m_send;
            if (m_send) begin
                if (m_age >= 2 && bus.tx_done_i) n_send = 0;
            end else if (wr_ctrl) begin
                n_send = bus.wdata_i[0];
            end
            if (bus.we_i && bus.addr_i && (!m_send || m_age == 0)) m_txd = bus.wdata_i[7:0];
            m_age  = (n_send && m_send) ? ((m_age < 3) ? m_age + 1 : 3) : 0;
            m_send = n_send;

            if (OVR_EN) begin
                if (bus.rx_valid_i && m_new && !clr_new) m_ovr = 1;
                else if (wr_ctrl && !bus.wdata_i[2])     m_ovr = 0;
            end
            if (bus.rx_valid_i) begin
                m_new = 1;
                m_rxd = bus.rx_data_i;
            end else if (clr_new) begin
                m_new = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model tx_start", {31'd0, bus.tx_start_o}, {31'd0, (m_send && m_age == 1)});
        chk("model tx_data",  {24'd0, bus.tx_data_o},  {24'd0, m_txd});
        chk("model ctrl_reg", bus.ctrl_reg_o, {29'd0, m_ovr, m_new, m_send});
        chk("model rx_data",  {24'd0, bus.rx_data_o},  {24'd0, m_rxd});
        if (bus.tx_start_o === 1'b1) pulse_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input bit we, input bit addr, input logic [31:0] wd,
                         input bit done, input bit rxv, input logic [7:0] rxd);
        bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wd;
        bus.tx_done_i = done; bus.rx_valid_i = rxv; bus.rx_data_i = rxd;
        tick();
        bus.we_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
        bus.tx_done_i = 0; bus.rx_valid_i = 0; bus.rx_data_i = 0;
    endtask

    int p0;

    initial begin
        rst = 1'b1;
        bus.we_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
        bus.tx_done_i = 0; bus.rx_valid_i = 0; bus.rx_data_i = 0;
        idle(3);
        rst = 1'b0;

        // Reset state and quiet idle period
        chk("reset ctrl_reg", bus.ctrl_reg_o, 32'h0);
        chk("reset tx_data", {24'd0, bus.tx_data_o}, 32'h0);
        chk("reset rx_data", {24'd0, bus.rx_data_o}, 32'h0);
        chk("reset tx_start", {31'd0, bus.tx_start_o}, 32'h0);
        p0 = pulse_cnt;
        idle(20);
        chk("idle no start", pulse_cnt - p0, 0);

        // Basic send of 0xA5
        drive(1, 1, 32'h0000_00A5, 0, 0, 8'h00);
        chk("data write", {24'd0, bus.tx_data_o}, 32'hA5);
        p0 = pulse_cnt;
        drive(1, 0, 32'h1, 0, 0, 8'h00);
        chk("send set", bus.ctrl_reg_o, 32'h1);
        chk("no start yet", {31'd0, bus.tx_start_o}, 32'h0);
        tick();
        chk("start pulse", {31'd0, bus.tx_start_o}, 32'h1);
        tick();
        chk("start ends", {31'd0, bus.tx_start_o}, 32'h0);

        // Writes during WAIT are ignored
        drive(1, 1, 32'h0000_003C, 0, 0, 8'h00);
        chk("busy data write", {24'd0, bus.tx_data_o}, 32'hA5);
        drive(1, 0, 32'h0, 0, 0, 8'h00);
        chk("busy ctrl write", bus.ctrl_reg_o, 32'h1);
        idle(3);
        drive(0, 0, 32'h0, 1, 0, 8'h00);
        chk("done clears", bus.ctrl_reg_o, 32'h0);
        chk("one pulse", pulse_cnt - p0, 1);

        // RX capture, and set-wins against a same-cycle clear
        drive(0, 0, 32'h0, 0, 1, 8'h5A);
        chk("rx byte", {24'd0, bus.rx_data_o}, 32'h5A);
        chk("rx_new set", bus.ctrl_reg_o, 32'h2);
        drive(1, 0, 32'h0, 0, 1, 8'h77);
        chk("rx overwrite", {24'd0, bus.rx_data_o}, 32'h77);
        chk("set wins", bus.ctrl_reg_o, 32'h2);
        drive(1, 0, 32'h2, 0, 0, 8'h00);
        chk("write1 no effect", bus.ctrl_reg_o, 32'h2);
        drive(1, 0, 32'h0, 0, 0, 8'h00);
        chk("rx_new clear", bus.ctrl_reg_o, 32'h0);

        // Reset during WAIT, then a late done
        drive(1, 0, 32'h1, 0, 0, 8'h00);
        idle(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid reset ctrl", bus.ctrl_reg_o, 32'h0);
        chk("mid reset data", {24'd0, bus.tx_data_o}, 32'h0);
        p0 = pulse_cnt;
        drive(0, 0, 32'h0, 1, 0, 8'h00);
        idle(5);
        chk("late done", bus.ctrl_reg_o, 32'h0);
        chk("no start after reset", pulse_cnt - p0, 0);

        // Done and a SEND write in the same cycle: the write is dropped
        drive(1, 1, 32'h0000_00C3, 0, 0, 8'h00);
        drive(1, 0, 32'h1, 0, 0, 8'h00);
        idle(4);
        drive(1, 0, 32'h1, 1, 0, 8'h00);
        chk("done vs write", bus.ctrl_reg_o, 32'h0);
        p0 = pulse_cnt;
        idle(5);
        chk("no restart", pulse_cnt - p0, 0);
        drive(0, 0, 32'h0, 1, 0, 8'h00);
        chk("idle done ignored", bus.ctrl_reg_o, 32'h0);
        drive(1, 0, 32'h1, 0, 0, 8'h00);
        chk("resend", bus.ctrl_reg_o, 32'h1);
        idle(3);
        drive(0, 0, 32'h0, 1, 0, 8'h00);
        chk("resend done", bus.ctrl_reg_o, 32'h0);
        chk("resend data", {24'd0, bus.tx_data_o}, 32'hC3);

        // Overrun: two bytes without a clear
        drive(0, 0, 32'h0, 0, 1, 8'h11);
        drive(0, 0, 32'h0, 0, 1, 8'h22);
        chk("overrun ctrl", bus.ctrl_reg_o, OVR_EN ? 32'h6 : 32'h2);
        drive(1, 0, 32'h4, 0, 0, 8'h00);
        chk("ovr write1", bus.ctrl_reg_o, OVR_EN ? 32'h4 : 32'h0);
        drive(1, 0, 32'h0, 0, 0, 8'h00);
        chk("overrun clear", bus.ctrl_reg_o, 32'h0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
